// File: rtl/dog_rd_seq.sv
// Frame read sequencer for the DoG datapath: row pass then column pass over a DIM x DIM image,
// each line followed by PAD edge-replicated samples, delivered as an aligned pixel stream.
module dog_rd_seq #(
  parameter int unsigned PAD      = 6,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LINE_GAP = 2,
  parameter int unsigned DIM      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  output logic        src_sel,
  input  logic [7:0]  rd_data_in,
  output logic        pix_valid_out,
  output logic [7:0]  pix_data_out,
  output logic        line_start,
  output logic        pass,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   XW      = $clog2(DIM + PAD + 1);
  localparam logic [XW-1:0] LastX   = XW'(DIM + PAD - 1);
  localparam logic [XW-1:0] DimX    = XW'(DIM);
  localparam logic [7:0]    LastY   = 8'(DIM - 1);
  localparam logic [3:0]    GapLast = 4'((LINE_GAP == 0) ? 0 : LINE_GAP - 1);
  localparam logic [3:0]    LatLast = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {StIdle, StLine, StGap, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          pass_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pad_q, first_q;
  logic          issue_d;
  logic [7:0]    xb_d;

  logic [RD_LAT-1:0] vld_q, padp_q, firstp_q;
  logic [7:0]        last_pix_q;
  logic              pad_out;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pass_d  = pass;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLine;
          x_d     = '0;
          y_d     = '0;
          pass_d  = 1'b0;
        end
      end
      StLine: begin
        if (x_q != LastX) begin
          x_d = x_q + XW'(1);
        end else begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q != LastY) begin
            y_d     = y_q + 8'd1;
            state_d = (LINE_GAP == 0) ? StLine : StGap;
          end else if (!pass) begin
            pass_d  = 1'b1;
            y_d     = '0;
            state_d = (LINE_GAP == 0) ? StLine : StGap;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StLine;
        else cnt_d = cnt_q + 4'd1;
      end
      StDrain: begin
        if (cnt_q == LatLast) state_d = StDone;
        else cnt_d = cnt_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Issue outputs are registered from the next state so they line up with the line cycle.
  assign issue_d = (state_d == StLine);
  assign xb_d    = 8'(x_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      pass    <= 1'b0;
      cnt_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      pad_q   <= 1'b0;
      first_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pass    <= pass_d;
      cnt_q   <= cnt_d;
      rd_en   <= issue_d && (x_d < DimX);
      pad_q   <= issue_d && (x_d >= DimX);
      first_q <= issue_d && (x_d == '0);
      if (issue_d && (x_d < DimX)) rd_addr <= pass_d ? {xb_d, y_d} : {y_d, xb_d};
      busy    <= (state_d == StLine) || (state_d == StGap) || (state_d == StDrain);
      done    <= (state_d == StDone);
    end
  end

  // Sideband pipeline matched to the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      padp_q     <= '0;
      firstp_q   <= '0;
      last_pix_q <= '0;
    end else begin
      vld_q[0]    <= rd_en | pad_q;
      padp_q[0]   <= pad_q;
      firstp_q[0] <= first_q;
      for (int k = 1; k < int'(RD_LAT); k++) begin
        vld_q[k]    <= vld_q[k-1];
        padp_q[k]   <= padp_q[k-1];
        firstp_q[k] <= firstp_q[k-1];
      end
      if (pix_valid_out && !pad_out) last_pix_q <= rd_data_in;
    end
  end

  assign pix_valid_out = vld_q[RD_LAT-1];
  assign pad_out       = padp_q[RD_LAT-1];
  assign line_start    = firstp_q[RD_LAT-1];
  assign pix_data_out  = !pix_valid_out ? 8'h00 : (pad_out ? last_pix_q : rd_data_in);
  assign src_sel       = pass;

endmodule

// File: tb/tb_dog_rd_seq.sv
// Bench for dog_rd_seq: two instances (RD_LAT=1/GAP=2 and RD_LAT=3/GAP=0) on a 16x16 image,
// checked every cycle against a frame-timing model computed from cycle offsets.
module tb_dog_rd_seq;

  localparam int DIM = 16;
  localparam int PAD = 6;

  typedef struct packed {
    logic        rd_en;
    logic [15:0] addr;
    logic        pv;
    logic [7:0]  pd;
    logic        ls;
    logic        busy;
    logic        done;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_w   [2];
  logic        rd_en_w   [2];
  logic [15:0] rd_addr_w [2];
  logic        src_w     [2];
  logic [7:0]  rd_data_w [2];
  logic        pv_w      [2];
  logic [7:0]  pd_w      [2];
  logic        ls_w      [2];
  logic        pass_w    [2];
  logic        busy_w    [2];
  logic        done_w    [2];

  int         lat [2] = '{1, 3};
  int         gap [2] = '{2, 0};
  int         t   [2] = '{0, 0};
  bit         act [2] = '{1'b0, 1'b0};
  int         nf  [2] = '{0, 0};
  logic [7:0] key [2] = '{8'h00, 8'h00};
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  dog_rd_seq #(.PAD(PAD), .RD_LAT(1), .LINE_GAP(2), .DIM(DIM)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]),
    .src_sel(src_w[0]), .rd_data_in(rd_data_w[0]), .pix_valid_out(pv_w[0]),
    .pix_data_out(pd_w[0]), .line_start(ls_w[0]), .pass(pass_w[0]), .busy(busy_w[0]),
    .done(done_w[0])
  );

  dog_rd_seq #(.PAD(PAD), .RD_LAT(3), .LINE_GAP(0), .DIM(DIM)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]),
    .src_sel(src_w[1]), .rd_data_in(rd_data_w[1]), .pix_valid_out(pv_w[1]),
    .pix_data_out(pd_w[1]), .line_start(ls_w[1]), .pass(pass_w[1]), .busy(busy_w[1]),
    .done(done_w[1])
  );

  function automatic logic [7:0] ramf(input logic [15:0] a, input logic [7:0] k);
    return a[7:0] ^ a[15:8] ^ k;
  endfunction

  // Synchronous RAM models with 1- and 3-cycle read latency.
  logic [7:0] ram_a;
  logic [7:0] ram_b [3];
  always @(posedge clk) begin
    ram_a    <= ramf(rd_addr_w[0], key[0]);
    ram_b[0] <= ramf(rd_addr_w[1], key[1]);
    ram_b[1] <= ram_b[0];
    ram_b[2] <= ram_b[1];
  end
  assign rd_data_w[0] = ram_a;
  assign rd_data_w[1] = ram_b[2];

  function automatic int last_t(input int i);
    return 2 * DIM * (DIM + PAD) + (2 * DIM - 1) * gap[i];
  endfunction

  function automatic int done_t(input int i);
    return last_t(i) + lat[i] + 1;
  endfunction

  function automatic logic [15:0] addr_of(input int x, input int y, input int p);
    return (p != 0) ? 16'(((x & 255) << 8) | y) : 16'((y << 8) | (x & 255));
  endfunction

  // Which line sample (if any) is issued tt cycles after the start was sampled.
  function automatic void issue_at(input int i, input int tt, output bit iss,
                                   output int x, output int y, output int p);
    int k, per, line;
    per = DIM + PAD + gap[i];
    iss = 1'b0; x = 0; y = 0; p = 0;
    if (tt < 1 || tt > last_t(i)) return;
    k    = tt - 1;
    line = k / per;
    if (k % per >= DIM + PAD) return;
    iss = 1'b1;
    x   = k % per;
    y   = line % DIM;
    p   = line / DIM;
  endfunction

  function automatic exp_t model(input int i);
    exp_t e;
    bit   iss;
    int   x, y, p, tt;
    e = '0;
    if (!act[i]) return e;
    tt = t[i];
    issue_at(i, tt, iss, x, y, p);
    e.rd_en = iss && (x < DIM);
    e.addr  = addr_of(x, y, p);
    issue_at(i, tt - lat[i], iss, x, y, p);
    e.pv    = iss;
    e.ls    = iss && (x == 0);
    e.pd    = iss ? ramf(addr_of((x < DIM) ? x : DIM - 1, y, p), key[i]) : 8'h00;
    e.busy  = (tt >= 1) && (tt <= last_t(i) + lat[i]);
    e.done  = (tt == done_t(i));
    e.pass  = tt > DIM * (DIM + PAD + gap[i]) - gap[i];
    return e;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s dut%0d cyc=%0d t=%0d got=%0h want=%0h", tag, i, cyc, t[i], obs, want);
    end
  endtask

  task automatic check(input int i);
    exp_t e;
    int   per;
    e   = model(i);
    per = DIM + PAD + gap[i];
    chk("rd_en", i, 32'(rd_en_w[i]), 32'(e.rd_en));
    if (e.rd_en) chk("rd_addr", i, 32'(rd_addr_w[i]), 32'(e.addr));
    chk("pix_valid", i, 32'(pv_w[i]), 32'(e.pv));
    chk("pix_data", i, 32'(pd_w[i]), 32'(e.pd));
    chk("line_start", i, 32'(ls_w[i]), 32'(e.ls));
    chk("busy", i, 32'(busy_w[i]), 32'(e.busy));
    chk("done", i, 32'(done_w[i]), 32'(e.done));
    chk("pass", i, 32'(pass_w[i]), 32'(e.pass));
    chk("src_sel", i, 32'(src_w[i]), 32'(e.pass));
    // Literal spot checks: address map and edge replication of 0x5A on the first line.
    if (act[i] && t[i] == 3 * per + 11) chk("addr_row_y3_x10", i, 32'(rd_addr_w[i]), 32'h030A);
    if (act[i] && t[i] == (DIM + 3) * per + 11)
      chk("addr_col_y3_x10", i, 32'(rd_addr_w[i]), 32'h0A03);
    if (act[i] && nf[i] == 1 && t[i] >= lat[i] + DIM && t[i] <= lat[i] + DIM + PAD)
      chk("pad_repl_5a", i, 32'(pd_w[i]), 32'h5A);
    if (act[i] && nf[i] == 1 && t[i] == lat[i] + 1 + per)
      chk("next_line_start", i, 32'(ls_w[i]), 32'h1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (act[i]) t[i]++;
      check(i);
    end
  endtask

  // A start is honoured only while idle; the first frame uses a key that puts 0x5A at x=DIM-1.
  task automatic pulse(input int i);
    start_w[i] = 1'b1;
    if (rst_n && (!act[i] || t[i] > done_t(i))) begin
      act[i] = 1'b1;
      t[i]   = 0;
      key[i] = (nf[i] == 0) ? 8'h55 : 8'($urandom);
      nf[i]++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Full frames with starts at t=500, at the done cycle (ignored) and just after (accepted).
    pulse(0);
    pulse(1);
    for (int n = 0; n < 1600; n++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (nf[i] < 3 && (t[i] == 500 || t[i] == done_t(i) || t[i] == done_t(i) + 1)) pulse(i);
    end

    // Mid-frame reset, then a fresh frame.
    for (int n = 0; n < 1000 && !(act[0] && t[0] >= 300 && t[0] < last_t(0)); n++) begin
      tick();
      if (!act[0] || t[0] > done_t(0)) pulse(0);
    end
    rst_n  = 1'b0;
    act[0] = 1'b0;
    act[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse(0);
    pulse(1);
    repeat (800) tick();

    // Random start pulses; the model decides which ones are accepted.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 39) == 0) pulse(i);
    end
    repeat (800) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
